// File: rtl/char_text_buffer_pkg.sv
// char_text_buffer_pkg: shared constants, FSM state type and cursor/glyph helpers.
package char_text_buffer_pkg;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;
  localparam int GLYPH_H = 16;
  localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
  localparam logic [7:0] CHAR_CLEAR = 8'h0C;
  typedef enum logic {IDLE, CLEAR} state_t;
  // Arithmetic glyph set: code 0x20 is blank, every other code gets a distinct stripe pattern.
  function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] l);
    return (c == 7'h20) ? 8'h00 : ({c, 1'b0} ^ {l, l});
  endfunction
  function automatic logic [3:0] next_row(input logic [3:0] r);
    return (r == 4'(TEXT_ROWS - 1)) ? 4'h0 : r + 4'h1;
  endfunction
  function automatic logic [7:0] next_cell(input logic [7:0] xy);
    return (xy[7:4] == 4'(TEXT_COLS - 1)) ? {4'h0, next_row(xy[3:0])} : {xy[7:4] + 4'h1, xy[3:0]};
  endfunction
  function automatic logic [7:0] newline(input logic [7:0] xy);
    return {4'h0, next_row(xy[3:0])};
  endfunction
endpackage

// File: rtl/char_text_buffer_if.sv
// char_text_buffer_if: write byte stream plus glyph read path of the text buffer.
interface char_text_buffer_if;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixel;
  logic wr_valid;
  logic wr_ready;
  logic [7:0] wr_data;
  logic [7:0] cursor_xy;
  modport master (
    output char_xy, char_line, wr_valid, wr_data,
    input  char_pixel, wr_ready, cursor_xy
  );
  modport slave (
    input  char_xy, char_line, wr_valid, wr_data,
    output char_pixel, wr_ready, cursor_xy
  );
endinterface

// File: rtl/char_text_buffer_font_rom.sv
// font_rom: 128 x 16 x 8 glyph ROM, registered output with optional inverse video.
module font_rom
  import char_text_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic [6:0] code,
  input  logic inv,
  input  logic [$clog2(GLYPH_H)-1:0] line,
  output logic [7:0] pixel
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pixel <= 8'h00;
    else pixel <= glyph(code, line) ^ {8{inv}};
endmodule

// File: rtl/char_text_buffer.sv
// char_text_buffer: 16x16 character RAM with cursor-driven writer, clear engine and 2-stage glyph read path.
module char_text_buffer
  import char_text_buffer_pkg::*;
#(
  parameter logic [7:0] CLEAR_CODE = 8'h20
) (
  input logic clk,
  input logic rst_n,
  char_text_buffer_if.slave bus
);
  logic [7:0] ram [256];
  state_t state;
  logic [7:0] clr_addr, cursor, code, waddr, wdata, pixel;
  logic [3:0] line_q;
  logic ready, accept, is_nl, is_clr, we;
  assign accept = bus.wr_valid && ready;
  assign is_nl = bus.wr_data == CHAR_NEWLINE;
  assign is_clr = bus.wr_data == CHAR_CLEAR;
  assign bus.wr_ready = ready;
  assign bus.cursor_xy = cursor;
  assign bus.char_pixel = pixel;
  always_comb begin
    we = rst_n && (state == CLEAR || (accept && !is_nl && !is_clr));
    waddr = (state == CLEAR) ? clr_addr : cursor;
    wdata = (state == CLEAR) ? CLEAR_CODE : bus.wr_data;
  end
  always_ff @(posedge clk)
    if (we) ram[waddr] <= wdata;
  // Read before write on a shared address: the code register sees the old byte.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      code <= 8'h00;
      line_q <= 4'h0;
    end else begin
      code <= ram[bus.char_xy];
      line_q <= bus.char_line;
    end
  font_rom u_font (
    .clk(clk),
    .rst_n(rst_n),
    .code(code[6:0]),
    .inv(code[7]),
    .line(line_q),
    .pixel(pixel)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      clr_addr <= 8'h00;
      cursor <= 8'h00;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 8'd1;
      if (clr_addr == 8'hFF) begin
        state <= IDLE;
        ready <= 1'b1;
        cursor <= 8'h00;
      end
    end else if (accept) begin
      if (is_clr) begin
        state <= CLEAR;
        ready <= 1'b0;
        clr_addr <= 8'h00;
      end else cursor <= is_nl ? newline(cursor) : next_cell(cursor);
    end
endmodule

// File: tb/tb_char_text_buffer.sv
// tb_char_text_buffer: random stimulus against a cell/cursor reference model, scoreboard-checked.
module tb_char_text_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  char_text_buffer_if bus();
  char_text_buffer #(.CLEAR_CODE(8'h20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int due; logic [7:0] val;} pix_t;
  typedef struct {int due; logic rdy; logic [7:0] cur;} st_t;
  pix_t pix_q[$];
  st_t st_q[$];
  pix_t p;
  st_t s;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int ram_m[256];
  bit known[256];
  int clear_left = 256, col = 0, row = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Font as plain arithmetic: blank space, else 2*code xor 17*line, complemented for codes >= 128.
  function automatic int font_m(int c, int l);
    int g;
    g = ((c % 128) == 32) ? 0 : ((((c % 128) * 2) ^ (l * 17)) % 256);
    return (c >= 128) ? 255 - g : g;
  endfunction
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
  endtask
  task automatic step(input bit v, input int d, input int xy, input int ln);
    int idx;
    bus.wr_valid = v;
    bus.wr_data = d[7:0];
    bus.char_xy = xy[7:0];
    bus.char_line = ln[3:0];
    if (known[xy]) pix_q.push_back('{cyc + 2, 8'(font_m(ram_m[xy], ln)) });
    if (clear_left > 0) begin
      idx = 256 - clear_left;
      ram_m[idx] = 32;
      known[idx] = 1'b1;
      clear_left--;
      if (clear_left == 0) begin
        col = 0;
        row = 0;
      end
    end else if (v) begin
      if (d == 8'h0C) clear_left = 256;
      else if (d == 8'h0A) begin
        col = 0;
        row = (row + 1) % 16;
      end else begin
        ram_m[col * 16 + row] = d;
        known[col * 16 + row] = 1'b1;
        col++;
        if (col == 16) begin
          col = 0;
          row = (row + 1) % 16;
        end
      end
    end
    st_q.push_back('{cyc + 1, clear_left == 0, 8'(col * 16 + row)});
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    pix_q.delete();
    st_q.delete();
    clear_left = 256;
    col = 0;
    row = 0;
    #1;
    check("reset char_pixel", bus.char_pixel, 0);
    check("reset cursor_xy", bus.cursor_xy, 0);
    check("reset wr_ready", bus.wr_ready, 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && clear_left > 0; i++) step(0, 0, $urandom % 256, $urandom % 16);
  endtask
  task automatic sweep();
    for (int i = 0; i < 256; i++) step(0, 0, i, $urandom % 16);
  endtask
  always @(negedge clk) if (rst_n) begin
    while (pix_q.size() > 0 && pix_q[0].due < cyc) void'(pix_q.pop_front());
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      p = pix_q.pop_front();
      check("char_pixel", bus.char_pixel, p.val);
    end
    while (st_q.size() > 0 && st_q[0].due < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      s = st_q.pop_front();
      check("wr_ready", bus.wr_ready, s.rdy);
      check("cursor_xy", bus.cursor_xy, s.cur);
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    int r, d;
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'h00;
    bus.char_xy = 8'h00;
    bus.char_line = 4'h0;
    @(posedge clk);
    #1;
    do_reset(3);
    repeat (258) step(0, 0, $urandom % 256, $urandom % 16);
    sweep();
    step(1, 8'h41, 0, 5);
    repeat (2) step(0, 0, 0, 5);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom % 100;
      d = (r < 8) ? 8'h0A : (r < 9) ? 8'h0C : int'($urandom % 256);
      step(1'($urandom % 2), d, $urandom % 256, $urandom % 16);
    end
    wait_idle();
    for (int i = 0; i < 256; i++) step(1, $urandom_range(33, 126), $urandom % 256, $urandom % 16);
    sweep();
    step(1, 8'h0C, 0, 0);
    wait_idle();
    repeat (3) step(1, 8'h0A, 0, 0);
    repeat (5) step(1, 8'h42, 0, 0);
    step(1, 8'h0A, 8'h53, 1);
    repeat (12) step(1, 8'h0A, 8'h53, 2);
    for (int i = 0; i < 16; i++) step(0, 0, i * 16 + 3, i);
    step(1, 8'hC1, 0, 0);
    for (int l = 0; l < 16; l++) step(0, 0, 8'h00, l);
    step(1, 8'h0C, 0, 0);
    repeat (100) step(1, 8'h41, $urandom % 256, $urandom % 16);
    do_reset(2);
    repeat (258) step(clear_left > 0, 8'h41, $urandom % 256, $urandom % 16);
    sweep();
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/char_text_buffer.md
CHAR_TEXT_BUFFER -- requirements
Module: char_text_buffer

Interface
REQ-001 SHALL have a single clock and reset: clk input 1 (system/pixel clock, all logic on posedge); rst_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have port char_xy, input, 8 bits: glyph cell address {column[7:4], row[3:0]} from the text-drawing stage.
REQ-003 SHALL have port char_line, input, 4 bits: scan line within the glyph, 0..15.
REQ-004 SHALL have port char_pixel, output, 8 bits: glyph row; bit 7 is the leftmost pixel, 1 = ink.
REQ-005 SHALL have port wr_valid, input, 1 bit: a write byte is offered.
REQ-006 SHALL have port wr_ready, output, 1 bit: the block accepts the byte this cycle.
REQ-007 SHALL have port wr_data, input, 8 bits: character code or control byte.
REQ-008 SHALL have port cursor_xy, output, 8 bits: next write cell {column, row}.
REQ-009 SHALL have parameter CLEAR_CODE, default 8'h20, giving the code written during a clear.

Function
REQ-010 SHALL hold 256 x 8-bit text RAM; the address is {column, row}, matching char_xy.
REQ-011 SHALL implement the read path as a 2-stage pipeline: stage 1 registers code = RAM[char_xy] at edge n+1; stage 2 registers char_pixel = font[code[6:0]][char_line] at edge n+2, where char_line is sampled at edge n+1.
REQ-012 SHALL invert all 8 char_pixel bits when code[7]=1 (inverse video).
REQ-013 SHALL make the read path independent of the write path; on a same-cycle read and write to one address, the read returns the old data.
REQ-014 SHALL accept a byte on an edge where wr_valid=1 and wr_ready=1; wr_ready SHALL depend only on FSM state, never on wr_valid.
REQ-015 SHALL handle an accepted printable byte (any value except 8'h0A and 8'h0C) by writing RAM[cursor] and advancing the cursor.
REQ-016 SHALL advance the cursor as: column+1; column 15 wraps to 0 with row+1; cell (15,15) wraps to (0,0).
REQ-017 SHALL treat an accepted 8'h0A as newline: column to 0, row+1 (row 15 wraps to 0), no RAM write.
REQ-018 SHALL treat an accepted 8'h0C as clear: enter CLEAR, no cursor change until CLEAR ends.
REQ-019 SHALL have FSM states IDLE and CLEAR: IDLE has wr_ready=1; CLEAR has wr_ready=0, writes CLEAR_CODE to RAM[addr] with addr stepping 0..255, one per cycle.
REQ-020 SHALL go from CLEAR to IDLE on the edge after the addr=255 write, setting the cursor to 8'h00; CLEAR takes exactly 256 cycles.
REQ-021 SHALL keep the read pipeline running during CLEAR; cleared cells show the blank glyph.
REQ-022 SHALL update cursor_xy on the edge the byte is accepted.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously set: char_pixel=8'h00, cursor_xy=8'h00, state=CLEAR, clear addr=0, wr_ready=0, pipeline code register=8'h00.
REQ-024 SHALL, after release, run a full 256-cycle CLEAR before wr_ready rises.
REQ-025 SHALL make an rst_n assertion mid-CLEAR or mid-write restart CLEAR from addr 0; the RAM array itself is not reset.

Structure
REQ-026 SHALL define the shared package constants: TEXT_COLS=16, TEXT_ROWS=16, GLYPH_H=16, CHAR_NEWLINE=8'h0A, CHAR_CLEAR=8'h0C, and state typedef enum {IDLE, CLEAR}.
REQ-027 SHALL place the font in sub-module font_rom (128 x 16 x 8, synchronous read, 1-cycle latency, registered output), instanced as stage 2.

Verification
REQ-028 SHALL cover reset: release rst_n -> wr_ready=0 for 256 cycles, then 1; cursor_xy=8'h00; any char_xy gives char_pixel=8'h00 (glyph 0x20 is blank).
REQ-029 SHALL cover write and read: write 8'h41 at cursor 0; set char_xy=8'h00, char_line=4'd5 -> char_pixel=font['A'][5] exactly 2 edges later; cursor_xy=8'h10.
REQ-030 SHALL cover wrap: 256 consecutive writes with wr_valid held high -> cursor_xy back to 8'h00, one byte accepted per cycle, last byte at RAM[8'hFF].
REQ-031 SHALL cover newline: cursor 8'h53 (col5,row3), write 8'h0A -> cursor_xy=8'h04, no RAM change; at row 15 -> row 0.
REQ-032 SHALL cover inverse video: write 8'hC1 -> char_pixel = ~font['A'][line] on every line 0..15.
REQ-033 SHALL cover clear with reset mid-clear: write 8'h0C -> wr_ready low 256 cycles, all cells 8'h20; pulse rst_n low at clear addr 100 -> clear restarts at addr 0, a further 256 cycles.
